// File: rtl/bounce_box.sv
// bounce_box: pixel-pattern stage between the VGA timing core and the DVI encoder.
// Draws a solid square on a black background. The square moves diagonally,
// bounces off the screen edges, and changes colour on every bounce.
// The position is updated once per frame, at the vsync edge, so there is no tearing.
//
// Ports:
//   i_clk                pixel clock
//   i_rst                asynchronous, active-high reset
//   i_blank              1 = outside the active area
//   i_hsync, i_vsync     sync from the timing core (asserted level = SYNC_ACTIVE)
//   o_blank/o_hsync/o_vsync   inputs delayed by exactly 2 cycles
//   o_r, o_g, o_b        pixel colour, aligned with o_blank
//
// Optional feature: define BOUNCE_BOX_BORDER_EN to draw a 1-pixel white frame
// around the screen edge. The frame takes priority over the box, and the
// latency does not change.
module bounce_box #(
  parameter int   H_RES       = 640,
  parameter int   V_RES       = 480,
  parameter int   PIX_SZ      = 8,
  parameter int   BOX_SZ      = 32,
  parameter int   STEP        = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_blank,
  input  logic              i_hsync,
  input  logic              i_vsync,
  output logic              o_blank,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [PIX_SZ-1:0] o_r,
  output logic [PIX_SZ-1:0] o_g,
  output logic [PIX_SZ-1:0] o_b
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int XE = XW + 1;   // one extra bit so the bounce compares cannot wrap
  localparam int YE = YW + 1;

  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  localparam logic [XW-1:0] X_MAX   = XW'(H_RES - 1);
  localparam logic [XW-1:0] X_STOP  = XW'(H_RES - BOX_SZ);
  localparam logic [XW-1:0] X_STEP  = XW'(STEP);
  localparam logic [XE-1:0] H_E     = XE'(H_RES);
  localparam logic [XE-1:0] XSTEP_E = XE'(STEP);
  localparam logic [XE-1:0] XBOX_E  = XE'(BOX_SZ);

  localparam logic [YW-1:0] Y_MAX   = YW'(V_RES - 1);
  localparam logic [YW-1:0] Y_STOP  = YW'(V_RES - BOX_SZ);
  localparam logic [YW-1:0] Y_STEP  = YW'(STEP);
  localparam logic [YE-1:0] V_E     = YE'(V_RES);
  localparam logic [YE-1:0] YSTEP_E = YE'(STEP);
  localparam logic [YE-1:0] YBOX_E  = YE'(BOX_SZ);

  typedef enum logic {DIR_POS, DIR_NEG} dir_t;
  typedef enum logic [1:0] {RED, GREEN, BLUE, WHITE} colour_t;

  logic [XW-1:0] x_cnt, box_x, box_x_d;
  logic [YW-1:0] y_cnt, box_y, box_y_d;
  dir_t          dir_x, dir_x_d, dir_y, dir_y_d;
  logic          flip_x, flip_y;
  colour_t       colour_q, colour_d;
  logic          blank_prev, vs_prev, vs_edge;
  logic          s1_inside, s1_blank, s1_hsync, s1_vsync;
  logic [PIX_SZ-1:0] col_r, col_g, col_b, pix_r, pix_g, pix_b;
`ifdef BOUNCE_BOX_BORDER_EN
  logic          s1_border;
`endif

  // First cycle at the asserted level after a cycle at the idle level.
  assign vs_edge = (i_vsync == SYNC_ACTIVE) && (vs_prev != SYNC_ACTIVE);

  // Raster counters. y_cnt advances at the end of each active line (blank 0->1).
  // NOTE: clocked state uses non-blocking assignments so that every register
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      blank_prev <= 1'b1;
      vs_prev    <= SYNC_IDLE;
    end else begin
      blank_prev <= i_blank;
      vs_prev    <= i_vsync;
      if (i_blank)             x_cnt <= '0;
      else if (x_cnt != X_MAX) x_cnt <= x_cnt + 1'b1;
      if (vs_edge)                                            y_cnt <= '0;
      else if (i_blank && !blank_prev && (y_cnt != Y_MAX))    y_cnt <= y_cnt + 1'b1;
    end
  end

  // Next X position and direction for the coming frame.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    box_x_d = box_x;
    dir_x_d = dir_x;
    flip_x  = 1'b0;
    if (dir_x == DIR_POS) begin
      if (({1'b0, box_x} + XSTEP_E + XBOX_E) >= H_E) begin
        box_x_d = X_STOP;
        dir_x_d = DIR_NEG;
        flip_x  = 1'b1;
      end else begin
        box_x_d = box_x + X_STEP;
      end
    end else begin
      if ({1'b0, box_x} <= XSTEP_E) begin
        box_x_d = '0;
        dir_x_d = DIR_POS;
        flip_x  = 1'b1;
      end else begin
        box_x_d = box_x - X_STEP;
      end
    end
  end

  // Next Y position and direction; same rule as X against V_RES.
  always_comb begin
    box_y_d = box_y;
    dir_y_d = dir_y;
    flip_y  = 1'b0;
    if (dir_y == DIR_POS) begin
      if (({1'b0, box_y} + YSTEP_E + YBOX_E) >= V_E) begin
        box_y_d = Y_STOP;
        dir_y_d = DIR_NEG;
        flip_y  = 1'b1;
      end else begin
        box_y_d = box_y + Y_STEP;
      end
    end else begin
      if ({1'b0, box_y} <= YSTEP_E) begin
        box_y_d = '0;
        dir_y_d = DIR_POS;
        flip_y  = 1'b1;
      end else begin
        box_y_d = box_y - Y_STEP;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= DIR_POS;
      dir_y <= DIR_POS;
    end else if (vs_edge) begin
      box_x <= box_x_d;
      box_y <= box_y_d;
      dir_x <= dir_x_d;
      dir_y <= dir_y_d;
    end
  end

  // Colour FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) colour_q <= RED;
    else       colour_q <= colour_d;
  end

  // Colour FSM: next state. A corner hit flips both axes but advances only once.
  always_comb begin
    colour_d = colour_q;
    if (vs_edge && (flip_x || flip_y)) begin
      unique case (colour_q)
        RED:   colour_d = GREEN;
        GREEN: colour_d = BLUE;
        BLUE:  colour_d = WHITE;
        WHITE: colour_d = RED;
      endcase
    end
  end

  // Colour FSM: outputs.
  always_comb begin
    col_r = '0;
    col_g = '0;
    col_b = '0;
    unique case (colour_q)
      RED:   col_r = '1;
      GREEN: col_g = '1;
      BLUE:  col_b = '1;
      WHITE: begin col_r = '1; col_g = '1; col_b = '1; end
    endcase
  end

  // Stage 1: box hit test, registered alongside blank/sync.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_inside <= 1'b0;
      s1_blank  <= 1'b1;
      s1_hsync  <= SYNC_IDLE;
      s1_vsync  <= SYNC_IDLE;
`ifdef BOUNCE_BOX_BORDER_EN
      s1_border <= 1'b0;
`endif
    end else begin
      s1_inside <= (x_cnt >= box_x) && ({1'b0, x_cnt} < ({1'b0, box_x} + XBOX_E)) &&
                   (y_cnt >= box_y) && ({1'b0, y_cnt} < ({1'b0, box_y} + YBOX_E));
      s1_blank  <= i_blank;
      s1_hsync  <= i_hsync;
      s1_vsync  <= i_vsync;
`ifdef BOUNCE_BOX_BORDER_EN
      s1_border <= (x_cnt == '0) || (x_cnt == X_MAX) || (y_cnt == '0) || (y_cnt == Y_MAX);
`endif
    end
  end

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (!s1_blank) begin
`ifdef BOUNCE_BOX_BORDER_EN
      if (s1_border) begin
        pix_r = '1;
        pix_g = '1;
        pix_b = '1;
      end else
`endif
      if (s1_inside) begin
        pix_r = col_r;
        pix_g = col_g;
        pix_b = col_b;
      end
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_blank <= 1'b1;
      o_hsync <= SYNC_IDLE;
      o_vsync <= SYNC_IDLE;
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
    end else begin
      o_blank <= s1_blank;
      o_hsync <= s1_hsync;
      o_vsync <= s1_vsync;
      o_r     <= pix_r;
      o_g     <= pix_g;
      o_b     <= pix_b;
    end
  end

endmodule

// File: tb/tb_bounce_box.sv
// Testbench for bounce_box: two instances (16x12 and 16x16 screens, BOX_SZ=4,
// STEP=3, active-low sync) share one stimulus stream. Each frame is captured
// into a small framebuffer and selected pixels are compared against hand-derived
// box positions and colours; blank/sync are compared against the inputs two
// cycles earlier; a vector table covers blanked random-looking sync patterns.
module tb_bounce_box;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic clk = 1'b0;
  logic rst, blank, hs, vs;
  logic o1_blank, o1_hsync, o1_vsync, o2_blank, o2_hsync, o2_vsync;
  logic [7:0] o1_r, o1_g, o1_b, o2_r, o2_g, o2_b;

  always #5 clk = ~clk;

  bounce_box #(.H_RES(16), .V_RES(12), .PIX_SZ(8), .BOX_SZ(4), .STEP(3), .SYNC_ACTIVE(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_blank(blank), .i_hsync(hs), .i_vsync(vs),
    .o_blank(o1_blank), .o_hsync(o1_hsync), .o_vsync(o1_vsync),
    .o_r(o1_r), .o_g(o1_g), .o_b(o1_b));

  bounce_box #(.H_RES(16), .V_RES(16), .PIX_SZ(8), .BOX_SZ(4), .STEP(3), .SYNC_ACTIVE(1'b0)) dut_sq (
    .i_clk(clk), .i_rst(rst), .i_blank(blank), .i_hsync(hs), .i_vsync(vs),
    .o_blank(o2_blank), .o_hsync(o2_hsync), .o_vsync(o2_vsync),
    .o_r(o2_r), .o_g(o2_g), .o_b(o2_b));

  typedef struct {
    logic b, h, v;      // inputs applied this step
    logic eb, eh, ev;   // expected o_blank/o_hsync/o_vsync seen at this step
  } vec_t;

  vec_t tbl[14];

  int n_checks = 0;
  int n_fail   = 0;

  // Input history (index 1 = two steps ago) with pixel tags; x<0 = no pixel.
  logic h_b[2], h_h[2], h_v[2];
  int   h_x[2], h_y[2];
  int   hist_n = 0;
  logic smp_blank, smp_hsync, smp_vsync;
  logic [23:0] smp_rgb;
  logic [23:0] fb1[16][16];
  logic [23:0] fb2[16][16];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_px(input int x, input int y, input int v, input logic [23:0] col);
`ifdef BOUNCE_BOX_BORDER_EN
    if (x == 0 || x == 15 || y == 0 || y == v - 1) return WHITE;
`endif
    return col;
  endfunction

  task automatic px(input string tag, input int d, input int x, input int y, input logic [23:0] col);
    logic [23:0] act;
    int v;
    v   = (d == 1) ? 12 : 16;
    act = (d == 1) ? fb1[y][x] : fb2[y][x];
    check($sformatf("%s d%0d px(%0d,%0d)", tag, d, x, y), act, exp_px(x, y, v, col));
  endtask

  // One clock step: sample outputs belonging to the inputs of two steps ago,
  // check blank/sync alignment, capture the pixel, then drive the new inputs.
  task automatic step(input logic b, input logic h, input logic v, input int x, input int y);
    @(negedge clk);
    smp_blank = o1_blank;
    smp_hsync = o1_hsync;
    smp_vsync = o1_vsync;
    smp_rgb   = {o1_r, o1_g, o1_b};
    if (hist_n >= 2) begin
      check("align o_blank", {23'd0, o1_blank}, {23'd0, h_b[1]});
      check("align o_hsync", {23'd0, o1_hsync}, {23'd0, h_h[1]});
      check("align o_vsync", {23'd0, o1_vsync}, {23'd0, h_v[1]});
      check("align sq o_blank", {23'd0, o2_blank}, {23'd0, h_b[1]});
      if (h_x[1] >= 0) begin
        if (h_y[1] < 12) fb1[h_y[1]][h_x[1]] = {o1_r, o1_g, o1_b};
        fb2[h_y[1]][h_x[1]] = {o2_r, o2_g, o2_b};
      end
    end
    h_b[1] = h_b[0]; h_h[1] = h_h[0]; h_v[1] = h_v[0]; h_x[1] = h_x[0]; h_y[1] = h_y[0];
    h_b[0] = b;      h_h[0] = h;      h_v[0] = v;      h_x[0] = x;      h_y[0] = y;
    hist_n++;
    // NOTE: stimulus is driven with blocking assignments at the falling edge,
    // half a period away from the rising edge where the DUT samples it.
    blank = b;
    hs    = h;
    vs    = v;
  endtask

  task automatic frame();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        fb1[y][x] = 24'hxxxxxx;
        fb2[y][x] = 24'hxxxxxx;
      end
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) step(1'b0, 1'b1, 1'b1, x, y);
      step(1'b1, 1'b1, 1'b1, -1, -1);
      step(1'b1, 1'b0, 1'b1, -1, -1);
      step(1'b1, 1'b1, 1'b1, -1, -1);
    end
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b1, 1'b0, -1, -1);
    step(1'b1, 1'b1, 1'b0, -1, -1);
    step(1'b1, 1'b1, 1'b1, -1, -1);
    step(1'b1, 1'b1, 1'b1, -1, -1);
  endtask

  // Hold reset with non-idle inputs, check reset values, release during blanking.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; blank = 1'b0; hs = 1'b0; vs = 1'b0;
    repeat (2) @(negedge clk);
    check("rst o_blank", {23'd0, o1_blank}, 24'd1);
    check("rst o_hsync", {23'd0, o1_hsync}, 24'd1);
    check("rst o_vsync", {23'd0, o1_vsync}, 24'd1);
    check("rst rgb", {o1_r, o1_g, o1_b}, BLACK);
    check("rst sq o_blank", {23'd0, o2_blank}, 24'd1);
    blank = 1'b1; hs = 1'b1; vs = 1'b1; rst = 1'b0;
    hist_n = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Blanked sync vectors: expected outputs are the inputs two rows earlier
    // (rows 0/1 follow two idle steps of blank=1, hsync=1, vsync=1).
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; blank = 1'b1; hs = 1'b1; vs = 1'b1;

    // Reset and first frame: box at (0,0), RED.
    apply_reset();
    repeat (2) step(1'b1, 1'b1, 1'b1, -1, -1);
    frame();
    px("f0", 1, 0, 0, RED);
    px("f0", 1, 4, 0, BLACK);
    px("f0", 1, 3, 3, RED);
    px("f0", 1, 4, 3, BLACK);
    px("f0", 2, 3, 3, RED);

    // Edge 1: box (3,3).
    vsync_pulse(); frame();
    px("f1", 1, 3, 3, RED);
    px("f1", 1, 2, 3, BLACK);
    px("f1", 1, 6, 6, RED);
    px("f1", 1, 7, 6, BLACK);

    // Edge 2: box (6,6).
    vsync_pulse(); frame();
    px("f2", 1, 6, 6, RED);
    px("f2", 1, 9, 9, RED);
    px("f2", 1, 10, 9, BLACK);
    px("f2", 1, 5, 6, BLACK);

    // Edge 3: 12-line screen flips Y to 8 -> GREEN; square screen at (9,9) RED.
    vsync_pulse(); frame();
    px("f3", 1, 9, 8, GREEN);
    px("f3", 1, 12, 11, GREEN);
    px("f3", 1, 8, 8, BLACK);
    px("f3", 1, 9, 7, BLACK);
    px("f3", 2, 9, 9, RED);
    px("f3", 2, 12, 12, RED);

    // Edge 4: X flips to 12 -> BLUE, Y moves back to 5; corner hit on square screen.
    vsync_pulse(); frame();
    px("f4", 1, 12, 5, BLUE);
    px("f4", 1, 15, 8, BLUE);
    px("f4", 1, 11, 5, BLACK);
    px("f4", 1, 12, 4, BLACK);
    px("f4", 1, 12, 9, BLACK);
    px("f4 corner", 2, 12, 12, GREEN);
    px("f4 corner", 2, 15, 15, GREEN);
    px("f4 corner", 2, 11, 12, BLACK);
    px("f4 corner", 2, 12, 11, BLACK);

    // Async reset mid-line after 3 edges.
    apply_reset();
    repeat (2) step(1'b1, 1'b1, 1'b1, -1, -1);
    repeat (3) vsync_pulse();
    repeat (4) step(1'b0, 1'b1, 1'b1, -1, -1);
    repeat (4) step(1'b0, 1'b0, 1'b1, -1, -1);
    check("pre-rst o_blank", {23'd0, o1_blank}, 24'd0);
    check("pre-rst o_hsync", {23'd0, o1_hsync}, 24'd0);
    #2 rst = 1'b1;
    #1;
    check("async rst o_blank", {23'd0, o1_blank}, 24'd1);
    check("async rst o_hsync", {23'd0, o1_hsync}, 24'd1);
    check("async rst o_vsync", {23'd0, o1_vsync}, 24'd1);
    check("async rst rgb", {o1_r, o1_g, o1_b}, BLACK);
    @(negedge clk);
    blank = 1'b1; hs = 1'b1; vs = 1'b1; rst = 1'b0;
    hist_n = 0;
    repeat (2) step(1'b1, 1'b1, 1'b1, -1, -1);
    frame();
    px("post-rst", 1, 0, 0, RED);
    px("post-rst", 1, 3, 3, RED);
    px("post-rst", 1, 4, 3, BLACK);
    px("post-rst", 1, 15, 5, BLACK);

    // Blanked random sync with box covering (0,0): rgb stays 0, sync delayed 2.
    apply_reset();
    repeat (2) step(1'b1, 1'b1, 1'b1, -1, -1);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].b, tbl[i].h, tbl[i].v, -1, -1);
      check($sformatf("vec%0d o_blank", i), {23'd0, smp_blank}, {23'd0, tbl[i].eb});
      check($sformatf("vec%0d o_hsync", i), {23'd0, smp_hsync}, {23'd0, tbl[i].eh});
      check($sformatf("vec%0d o_vsync", i), {23'd0, smp_vsync}, {23'd0, tbl[i].ev});
      check($sformatf("vec%0d rgb", i), smp_rgb, BLACK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
